// File: rtl/adc_serial_rx.sv
// adc_serial_rx: SPI-style receiver for LTC2315-class serial ADCs.
// Generates SCK/CS_N from the system clock and captures N_CH ADCs in lockstep.
// It checks the leading-zero bits, drops the warm-up frames after each enable,
// and hands samples to the DSP chain over valid/ready with overrun detection.
//
// Ports:
//   clk, rst        system clock, async active-high reset
//   en_i            continuous conversion enable
//   sck_o, cs_n_o   serial clock / chip select shared by all ADCs
//   miso_i[N_CH]    serial data, one bit per ADC
//   data_o          samples, channel k at [k*DATA_W +: DATA_W]
//   err_o[N_CH]     leading-zero error for the sample in data_o
//   valid_o/ready_i sample handshake
//   overrun_o       sticky, a sample was overwritten before it was accepted
//   clr_ovr_i       clears overrun_o
//   busy_o          high whenever the FSM is not IDLE

// Per-channel capture: leading-zero check and data shift register.
module adc_serial_rx_lane #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_smp,
    input  logic              i_lead,
    input  logic              i_data,
    input  logic              i_miso,
    output logic [DATA_W-1:0] o_sh,
    output logic              o_err
);
    logic [DATA_W-1:0] r_sh;
    logic              r_err;

    // The shift register needs no clear because each frame rewrites all DATA_W bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_err <= 1'b0;
        end else if (i_clr) begin
            r_err <= 1'b0;
        end else if (i_smp) begin
            if (i_lead && i_miso) r_err <= 1'b1;
            if (i_data)           r_sh  <= (r_sh << 1) | DATA_W'(i_miso);
        end
    end

    assign o_sh  = r_sh;
    assign o_err = r_err;
endmodule

module adc_serial_rx #(
    parameter int DATA_W     = 12,
    parameter int N_CH       = 1,
    parameter int LEAD_ZEROS = 2,
    parameter int TRAIL_BITS = 0,
    parameter int CLK_DIV    = 2,
    parameter int QUIET_CYC  = 8,
    parameter int DISCARD    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    output logic                   sck_o,
    output logic                   cs_n_o,
    input  logic [N_CH-1:0]        miso_i,
    output logic [N_CH*DATA_W-1:0] data_o,
    output logic [N_CH-1:0]        err_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   overrun_o,
    input  logic                   clr_ovr_i,
    output logic                   busy_o
);
    localparam int BITS    = LEAD_ZEROS + DATA_W + TRAIL_BITS;
    localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(BITS + 1);
    localparam int DISC_W  = (DISCARD < 1) ? 1 : $clog2(DISCARD + 1);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] Q_LAST   = CNT_W'(QUIET_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_hi;       // current SCK half-period is the high one
    logic [BIT_W-1:0]       r_bit;
    logic [DISC_W-1:0]      r_disc;
    logic [N_CH*DATA_W-1:0] r_data;
    logic [N_CH-1:0]        r_err;
    logic                   r_valid;
    logic                   r_ovr;

    logic                   w_div_end, w_q_end, w_smp, w_done, w_keep, w_clr;
    logic                   w_lead, w_dat;
    int                     w_bit_n;
    logic [N_CH-1:0][DATA_W-1:0] w_sh;
    logic [N_CH-1:0]        w_err;

    assign w_div_end = (r_cnt == DIV_LAST);
    assign w_q_end   = (r_cnt == Q_LAST);
    // MISO is captured on the edge that ends the high phase (SCK 1 -> 0).
    assign w_smp     = (r_state == S_SHIFT) && r_hi && w_div_end;
    assign w_done    = (r_state == S_SHIFT) && !r_hi && w_div_end && (r_bit == BIT_LAST);
    assign w_keep    = w_done && (int'(r_disc) >= DISCARD);
    assign w_clr     = (r_state == S_SETUP);
    assign w_bit_n   = int'(r_bit);
    assign w_lead    = (w_bit_n < LEAD_ZEROS);
    assign w_dat     = (w_bit_n >= LEAD_ZEROS) && (w_bit_n < LEAD_ZEROS + DATA_W);

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        adc_serial_rx_lane #(.DATA_W(DATA_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_clr  (w_clr),
            .i_smp  (w_smp),
            .i_lead (w_lead),
            .i_data (w_dat),
            .i_miso (miso_i[k]),
            .o_sh   (w_sh[k]),
            .o_err  (w_err[k])
        );
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic; en_i only matters in IDLE and at the end of QUIET.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (en_i)      w_next = S_SETUP;
            S_SETUP: if (w_div_end) w_next = S_SHIFT;
            S_SHIFT: if (w_done)    w_next = S_QUIET;
            S_QUIET: if (w_q_end)   w_next = en_i ? S_SETUP : S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state so reset forces them immediately.
    always_comb begin
        cs_n_o = 1'b1;
        sck_o  = 1'b0;
        busy_o = (r_state != S_IDLE);
        case (r_state)
            S_SETUP: cs_n_o = 1'b0;
            S_SHIFT: begin
                cs_n_o = 1'b0;
                sck_o  = r_hi;
            end
            default: ;
        endcase
    end

    // Timing counters and the discard counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hi   <= 1'b0;
            r_bit  <= '0;
            r_disc <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_hi  <= 1'b0;
                    r_bit <= '0;
                    if (en_i) r_disc <= '0;
                end
                S_SETUP: begin
                    r_bit <= '0;
                    if (w_div_end) begin
                        r_cnt <= '0;
                        r_hi  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_div_end) begin
                        r_cnt <= '0;
                        r_hi  <= !r_hi;
                        if (!r_hi) r_bit <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_done && !w_keep) r_disc <= r_disc + 1'b1;
                end
                default: begin
                    r_hi <= 1'b0;
                    if (w_q_end) r_cnt <= '0;
                    else         r_cnt <= r_cnt + 1'b1;
                end
            endcase
        end
    end

    // Sample register and handshake. A completing frame always wins over a
    // transfer, so valid stays high when both happen on one edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_err   <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_keep) begin
                r_data  <= w_sh;
                r_err   <= w_err;
                r_valid <= 1'b1;
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
            if (w_keep && r_valid && !ready_i) r_ovr <= 1'b1;
            else if (clr_ovr_i)                r_ovr <= 1'b0;
        end
    end

    assign data_o    = r_data;
    assign err_o     = r_err;
    assign valid_o   = r_valid;
    assign overrun_o = r_ovr;
endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: one default instance (A) and one two-channel
// instance (B). ADC models serialise frame words; expected samples are
// queued at frame start and compared by monitors on each handshake.
module tb_adc_serial_rx;
    localparam int CLK_P  = 10;
    localparam int BITS_A = 14;
    localparam int BITS_B = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #(CLK_P/2) clk = ~clk;

    // instance A (defaults)
    logic        en_a = 1'b0, ready_a = 1'b1, clr_a = 1'b0;
    logic        sck_a, cs_n_a, valid_a, ovr_a, busy_a;
    logic [0:0]  miso_a = 1'b0;
    logic [11:0] data_a;
    logic [0:0]  err_a;

    // instance B (2 channels, 16 bit, 1 lead, 2 trail, CLK_DIV 1)
    logic        en_b = 1'b0, ready_b = 1'b1, clr_b = 1'b0;
    logic        sck_b, cs_n_b, valid_b, ovr_b, busy_b;
    logic [1:0]  miso_b = 2'b00;
    logic [31:0] data_b;
    logic [1:0]  err_b;

    adc_serial_rx u_dut_a (
        .clk(clk), .rst(rst), .en_i(en_a), .sck_o(sck_a), .cs_n_o(cs_n_a),
        .miso_i(miso_a), .data_o(data_a), .err_o(err_a), .valid_o(valid_a),
        .ready_i(ready_a), .overrun_o(ovr_a), .clr_ovr_i(clr_a), .busy_o(busy_a)
    );

    adc_serial_rx #(.DATA_W(16), .N_CH(2), .LEAD_ZEROS(1), .TRAIL_BITS(2),
                    .CLK_DIV(1), .QUIET_CYC(8), .DISCARD(3)) u_dut_b (
        .clk(clk), .rst(rst), .en_i(en_b), .sck_o(sck_b), .cs_n_o(cs_n_b),
        .miso_i(miso_b), .data_o(data_b), .err_o(err_b), .valid_o(valid_b),
        .ready_i(ready_b), .overrun_o(ovr_b), .clr_ovr_i(clr_b), .busy_o(busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [BITS_A-1:0]   txa_q[$];
    logic [2*BITS_B-1:0] txb_q[$];
    logic [12:0]         expa_q[$];   // {err, data}
    logic [33:0]         expb_q[$];   // {err1, err0, data1, data0}
    int  fa_cnt = 0, fb_cnt = 0;      // frames since the last enable
    logic rdy_rand = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // wait for n frame completions on A (cs_n rising); returns at posedge+1
    task automatic wait_done_a(input int n);
        int k = 0, t = 0;
        logic prev;
        prev = cs_n_a;
        while (k < n && t < 3000) begin
            @(posedge clk); #1;
            if (!prev && cs_n_a) k++;
            prev = cs_n_a;
            t++;
        end
        chk("a_wait_done", 64'(k), 64'(n));
    endtask

    task automatic wait_start_a();
        int t = 0;
        logic prev, seen;
        prev = cs_n_a;
        seen = 1'b0;
        while (!seen && t < 3000) begin
            @(posedge clk); #1;
            if (prev && !cs_n_a) seen = 1'b1;
            prev = cs_n_a;
            t++;
        end
        chk("a_wait_start", 64'(seen), 64'd1);
    endtask

    // ADC model A: word is {lead[1:0], data[11:0]} sent MSB first, one bit per SCK period
    initial begin
        logic [BITS_A-1:0] wa;
        forever begin
            @(negedge cs_n_a);
            if (txa_q.size() > 0) wa = txa_q.pop_front();
            else                  wa = BITS_A'($urandom);
            if (fa_cnt >= 3) expa_q.push_back({|wa[13:12], wa[11:0]});
            fa_cnt++;
            for (int i = 0; i < BITS_A; i++) begin
                @(posedge sck_a or posedge cs_n_a);
                if (cs_n_a) break;
                miso_a[0] = wa[BITS_A-1-i];
            end
        end
    end

    // ADC model B: per channel {lead, data[15:0], trail[1:0]}; ch1 in the upper half
    initial begin
        logic [2*BITS_B-1:0] wb;
        forever begin
            @(negedge cs_n_b);
            if (txb_q.size() > 0) wb = txb_q.pop_front();
            else                  wb = {BITS_B'($urandom), BITS_B'($urandom)};
            if (fb_cnt >= 3) expb_q.push_back({wb[37], wb[18], wb[36:21], wb[17:2]});
            fb_cnt++;
            for (int i = 0; i < BITS_B; i++) begin
                @(posedge sck_b or posedge cs_n_b);
                if (cs_n_b) break;
                miso_b[0] = wb[BITS_B-1-i];
                miso_b[1] = wb[2*BITS_B-1-i];
            end
        end
    end

    // monitors: a transfer happens on the next posedge when valid && ready
    always @(negedge clk) begin
        if (!rst && valid_a && ready_a) begin
            if (expa_q.size() == 0) chk("a_unexpected_valid", 64'(valid_a), 64'd0);
            else begin
                logic [12:0] e;
                e = expa_q.pop_front();
                chk("a_data", 64'(data_a), 64'(e[11:0]));
                chk("a_err", 64'(err_a), 64'(e[12]));
            end
        end
        if (!rst && valid_b && ready_b) begin
            if (expb_q.size() == 0) chk("b_unexpected_valid", 64'(valid_b), 64'd0);
            else begin
                logic [33:0] e;
                e = expb_q.pop_front();
                chk("b_data", 64'(data_b), 64'(e[31:0]));
                chk("b_err", 64'(err_b), 64'(e[33:32]));
            end
        end
    end

    // random consumer for A
    always @(posedge clk) begin
        #1;
        if (rdy_rand) ready_a = ($urandom_range(0, 1) == 1);
    end

    // A framing: CS_N low 58 clk, period 66 clk (first frames, continuous run)
    initial begin
        time t_fall, t_prev;
        int  nm;
        nm = 0;
        t_prev = 0;
        forever begin
            @(negedge cs_n_a);
            t_fall = $time;
            if (nm > 0 && nm < 5) chk("a_frame_period", 64'((t_fall - t_prev) / CLK_P), 64'd66);
            @(posedge cs_n_a);
            if (nm < 5) chk("a_cs_low_cycles", 64'(($time - t_fall) / CLK_P), 64'd58);
            t_prev = t_fall;
            nm++;
        end
    end

    // B: SCK pulses per frame
    initial begin
        int cnt, nb;
        nb = 0;
        forever begin
            @(negedge cs_n_b);
            cnt = 0;
            forever begin
                @(posedge sck_b or posedge cs_n_b);
                if (cs_n_b) break;
                cnt++;
            end
            if (nb < 4 && !rst) chk("b_sck_pulses", 64'(cnt), 64'd19);
            nb++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck", 64'(sck_a), 64'd0);
        chk("rst_cs_n", 64'(cs_n_a), 64'd1);
        chk("rst_data", 64'(data_a), 64'd0);
        chk("rst_err", 64'(err_a), 64'd0);
        chk("rst_valid", 64'(valid_a), 64'd0);
        chk("rst_ovr", 64'(ovr_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_b_data", 64'(data_b), 64'd0);
        @(negedge clk) rst = 1'b0;

        repeat (4) txa_q.push_back(14'h0A5C);
        repeat (5) txb_q.push_back({1'b0, 16'h1234, 2'b10, 1'b0, 16'hBEEF, 2'b01});
        @(posedge clk); #1;
        en_a = 1'b1;
        en_b = 1'b1;

        // warm-up frames dropped, 4th delivered as a one-cycle pulse
        wait_done_a(3);
        chk("a_discard_valid", 64'(valid_a), 64'd0);
        chk("a_discard_data", 64'(data_a), 64'd0);
        wait_done_a(1);
        chk("a_first_valid", 64'(valid_a), 64'd1);
        chk("a_first_data", 64'(data_a), 64'hA5C);
        chk("a_first_err", 64'(err_a), 64'd0);
        @(posedge clk); #1;
        chk("a_valid_pulse", 64'(valid_a), 64'd0);

        // leading-zero error then a clean frame
        wait_done_a(1);
        txa_q.push_back({2'b01, 12'h123});
        txa_q.push_back({2'b00, 12'h456});
        wait_done_a(1);
        chk("a_lead_err", 64'(err_a), 64'd1);
        chk("a_lead_data", 64'(data_a), 64'h123);
        wait_done_a(1);
        chk("a_lead_ok", 64'(err_a), 64'd0);

        // overrun: two frames delivered with no consumer
        repeat (3) @(posedge clk);
        #1;
        ready_a = 1'b0;
        txa_q.push_back({2'b00, 12'h111});
        txa_q.push_back({2'b00, 12'h222});
        wait_done_a(2);
        chk("ovr_queue_depth", 64'(expa_q.size()), 64'd2);
        if (expa_q.size() > 0) void'(expa_q.pop_front());  // 0x111 was overwritten
        chk("ovr_data", 64'(data_a), 64'h222);
        chk("ovr_valid", 64'(valid_a), 64'd1);
        chk("ovr_flag", 64'(ovr_a), 64'd1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("ovr_cleared", 64'(ovr_a), 64'd0);
        chk("ovr_hold_data", 64'(data_a), 64'h222);
        ready_a = 1'b1;
        @(posedge clk); #1;
        chk("ovr_drained", 64'(valid_a), 64'd0);

        // en_i dropped mid-SHIFT: frame still delivered, then IDLE
        wait_start_a();
        repeat (20) @(posedge clk);
        #1;
        en_a = 1'b0;
        wait_done_a(1);
        chk("endrop_valid", 64'(valid_a), 64'd1);
        repeat (11) @(posedge clk);
        #1;
        chk("endrop_busy", 64'(busy_a), 64'd0);
        chk("endrop_cs_n", 64'(cs_n_a), 64'd1);
        fa_cnt = 0;
        en_a = 1'b1;
        wait_done_a(3);
        chk("reen_discard", 64'(valid_a), 64'd0);
        wait_done_a(1);
        chk("reen_deliver", 64'(valid_a), 64'd1);

        // randomized data and consumer
        rdy_rand = 1'b1;
        wait_done_a(12);
        rdy_rand = 1'b0;
        ready_a = 1'b1;
        chk("rand_no_ovr", 64'(ovr_a), 64'd0);
        chk("b_no_ovr", 64'(ovr_b), 64'd0);

        // asynchronous reset in the middle of SHIFT
        wait_start_a();
        repeat (20) @(posedge clk);
        #2;
        chk("a_inflight", 64'(expa_q.size()), 64'd1);
        chk("b_inflight", 64'(expb_q.size() <= 1), 64'd1);
        rst = 1'b1;
        #1;
        chk("arst_cs_n", 64'(cs_n_a), 64'd1);
        chk("arst_sck", 64'(sck_a), 64'd0);
        chk("arst_valid", 64'(valid_a), 64'd0);
        chk("arst_busy", 64'(busy_a), 64'd0);
        chk("arst_data", 64'(data_a), 64'd0);
        chk("arst_b_cs_n", 64'(cs_n_b), 64'd1);
        chk("arst_b_valid", 64'(valid_b), 64'd0);
        en_a = 1'b0;
        en_b = 1'b0;
        expa_q.delete();
        expb_q.delete();
        repeat (5) @(posedge clk);
        #1;
        chk("arst_hold_cs_n", 64'(cs_n_a), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_serial_rx.md
Name: adc_serial_rx

Overview:
- Parametrised SPI-style receiver for LTC2315-class serial ADCs.
- Successor to the single-channel, SCK-clocked ADC interface. It runs on the system clock and generates SCK and CS_N internally.
- Captures N_CH ADCs in lockstep. The ADCs share SCK/CS_N, and each has its own MISO.
- Checks the leading-zero bits and discards the warm-up samples. Delivers samples over a valid/ready handshake with overrun detection, between the ADC pins and the receiver DSP chain.

Parameters:
- DATA_W, 12, conversion result width.
- N_CH, 1, number of ADCs sharing SCK/CS_N.
- LEAD_ZEROS, 2, leading bits per frame that must read 0.
- TRAIL_BITS, 0, bits clocked after the data and ignored.
- CLK_DIV, 2, clk cycles per SCK half-period (>=1).
- QUIET_CYC, 8, clk cycles CS_N is held high between frames (>=1).
- DISCARD, 3, valid frames dropped after each enable.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset: asynchronous, active-high.
- en_i, in, 1, continuous conversion enable.
- sck_o, out, 1, serial clock to the ADCs.
- cs_n_o, out, 1, chip select to the ADCs, active-low.
- miso_i, in, N_CH, serial data, one bit per ADC.
- data_o, out, N_CH*DATA_W, samples; channel k occupies bits [k*DATA_W +: DATA_W].
- err_o, out, N_CH, per-channel leading-zero error for the sample in data_o.
- valid_o, out, 1, data_o/err_o hold a sample.
- ready_i, in, 1, consumer accepts the sample.
- overrun_o, out, 1, sticky: a sample was overwritten before it was accepted.
- clr_ovr_i, in, 1, clears overrun_o.
- busy_o, out, 1, high in any state except IDLE.

Behaviour:
- Reset (async, immediate):
  - sck_o=0, cs_n_o=1.
  - data_o=0, err_o=0, valid_o=0, overrun_o=0, busy_o=0.
  - State=IDLE, discard counter=0.
- Derived: BITS = LEAD_ZEROS + DATA_W + TRAIL_BITS.
- Frame period = CLK_DIV + 2*CLK_DIV*BITS + QUIET_CYC clk cycles (defaults: 2+56+8 = 66).
- FSM states: IDLE -> SETUP -> SHIFT -> QUIET.
- IDLE:
  - cs_n_o=1, sck_o=0.
  - When en_i=1: clear the discard counter and go to SETUP next cycle.
- SETUP:
  - cs_n_o=0, sck_o=0 for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - BITS SCK periods. Each period is sck_o high for CLK_DIV cycles, then low for CLK_DIV cycles.
  - miso_i is sampled on the clk edge that drives sck_o from 1 to 0, MSB first.
  - Bit index 0..BITS-1.
  - Bits 0..LEAD_ZEROS-1: err[k] is set if any of them is 1 on channel k.
  - Bits LEAD_ZEROS..LEAD_ZEROS+DATA_W-1: shifted into the channel's data, MSB first.
  - Trailing bits are ignored.
- End of SHIFT:
  - On the clk edge ending the last low phase, cs_n_o goes to 1 and the state moves to QUIET.
  - Frame completion occurs on that same edge.
- QUIET:
  - cs_n_o=1 for QUIET_CYC cycles.
  - Then go to SETUP if en_i=1, else to IDLE.
  - en_i is only sampled in IDLE and at the end of QUIET. Deasserting it mid-frame completes and delivers the current frame.
- Frame completion:
  - If discard counter < DISCARD: increment the counter and drop the frame (outputs unchanged).
  - Otherwise, on that clk edge: load data_o/err_o and set valid_o=1.
  - If valid_o was already 1 and ready_i=0 on that edge, the old sample is overwritten and overrun_o is set.
- Handshake:
  - Transfer occurs when valid_o && ready_i; valid_o drops on the next edge.
  - data_o/err_o are stable while valid_o=1 and no new frame completes.
  - Transfer and completion on the same edge: the new sample loads, valid_o stays 1, no overrun.
- Overrun clear: clr_ovr_i clears overrun_o; a simultaneous set wins.
- Discard counter: saturates at DISCARD. It resets only on rst and on leaving IDLE, so each re-enable drops DISCARD frames again.
- Reset mid-frame: outputs return to reset values immediately and the partial frame is lost.

Test Plan:
- Defaults, en_i=1, ready_i=1, constant MISO pattern 00 + 0xA5C: first 3 frames dropped; valid_o pulses 1 cycle at the end of the 4th frame with data_o=0xA5C, err_o=0; cs_n_o low exactly 58 clk per frame, period 66 clk.
- Leading bits 01 then data 0x123: data_o=0x123, err_o=1. The next frame with 00 gives err_o=0.
- ready_i=0 across two delivered frames 0x111 then 0x222: data_o=0x222, valid_o=1, overrun_o=1. clr_ovr_i for 1 cycle -> overrun_o=0.
- N_CH=2, DATA_W=16, LEAD_ZEROS=1, TRAIL_BITS=2, CLK_DIV=1: ch0=0xBEEF, ch1=0x1234 -> data_o=0x1234BEEF; 19 SCK pulses per frame.
- en_i dropped mid-SHIFT: the frame completes and is delivered, then IDLE with busy_o=0. Re-enable -> 3 frames are discarded again.
- rst asserted mid-SHIFT: cs_n_o=1, sck_o=0, valid_o=0 asynchronously, before the next clk edge.
